// File: rtl/sw_pkg.sv
// Shared types and defaults for the stopwatch input-conditioning block.
package sw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        HIGH = 2'd2,
        FALL = 2'd3
    } db_state_t;

    localparam int unsigned DB_CYCLES_DEF = 1_000_000;
    localparam int unsigned CNT_W_DEF     = 20;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce FSM for one raw board input.
// level/rise are combinational from the flopped state so the parent's output register lands at 2+DB_CYCLES edges.
module btn_debounce
    import sw_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic RESET,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment: the counter can never wrap back into a false qualify.
    assign cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (RESET) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            s1    <= din;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_nxt = RISE;
                    cnt_nxt   = '0;
                end
            end
            RISE: begin
                if (!s2) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_LAST) state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_nxt = FALL;
                    cnt_nxt   = '0;
                end
            end
            FALL: begin
                if (s2) begin
                    state_nxt = HIGH;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_LAST) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        level = (state_nxt == HIGH) || (state_nxt == FALL);
        rise  = (state == RISE) && (state_nxt == HIGH);
    end

endmodule

// File: rtl/sw_input_cond.sv
// Debounces the stopwatch buttons/switches into registered PAUSE, RST_PULSE, ADJ, SEL; 2+DB_CYCLES edges, no backpressure.
// SW_PAUSE_TOGGLE_EN: defined -> PAUSE toggles per press (cleared by RST_PULSE); undefined -> PAUSE follows the held button.
module sw_input_cond
    import sw_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic RESET,
    input  logic BTN_PAUSE,
    input  logic BTN_RST,
    input  logic SW_ADJ,
    input  logic SW_SEL,
    output logic PAUSE,
    output logic RST_PULSE,
    output logic ADJ,
    output logic SEL
);

    logic pause_lvl, pause_rise;
    logic rst_lvl,   rst_rise;
    logic adj_lvl,   adj_rise;
    logic sel_lvl,   sel_rise;
    logic unused_bits;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_pause (
        .clk(clk), .RESET(RESET), .din(BTN_PAUSE), .level(pause_lvl), .rise(pause_rise)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_rst (
        .clk(clk), .RESET(RESET), .din(BTN_RST), .level(rst_lvl), .rise(rst_rise)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_adj (
        .clk(clk), .RESET(RESET), .din(SW_ADJ), .level(adj_lvl), .rise(adj_rise)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_sel (
        .clk(clk), .RESET(RESET), .din(SW_SEL), .level(sel_lvl), .rise(sel_rise)
    );

`ifdef SW_PAUSE_TOGGLE_EN
    assign unused_bits = ^{pause_lvl, rst_lvl, adj_rise, sel_rise};
`else
    assign unused_bits = ^{pause_rise, rst_lvl, adj_rise, sel_rise};
`endif

    always_ff @(posedge clk) begin
        if (RESET) begin
            PAUSE     <= 1'b0;
            RST_PULSE <= 1'b0;
            ADJ       <= 1'b0;
            SEL       <= 1'b0;
        end else begin
            RST_PULSE <= rst_rise;
            ADJ       <= adj_lvl;
            SEL       <= sel_lvl;
`ifdef SW_PAUSE_TOGGLE_EN
            // A clear press beats a simultaneous pause press so a paused watch always clears.
            if (rst_rise)
                PAUSE <= 1'b0;
            else if (pause_rise)
                PAUSE <= ~PAUSE;
`else
            PAUSE <= pause_lvl;
`endif
        end
    end

endmodule

// File: tb/tb_sw_input_cond.sv
// Directed bench for sw_input_cond with DB_CYCLES=4 (qualified edges appear 6 clocks after the raw edge).
module tb_sw_input_cond;

    logic clk = 1'b0;
    logic RESET;
    logic BTN_PAUSE;
    logic BTN_RST;
    logic SW_ADJ;
    logic SW_SEL;
    logic PAUSE;
    logic RST_PULSE;
    logic ADJ;
    logic SEL;

    int total = 0;
    int bad   = 0;
    int pulses;
    int sel_hi;

`ifdef SW_PAUSE_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    always #5 clk = ~clk;

    sw_input_cond #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk),
        .RESET(RESET),
        .BTN_PAUSE(BTN_PAUSE),
        .BTN_RST(BTN_RST),
        .SW_ADJ(SW_ADJ),
        .SW_SEL(SW_SEL),
        .PAUSE(PAUSE),
        .RST_PULSE(RST_PULSE),
        .ADJ(ADJ),
        .SEL(SEL)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_cnt(input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            pulses += int'(RST_PULSE);
            sel_hi += int'(SEL);
        end
    endtask

    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%b exp=%b", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; BTN_PAUSE = 1'b0; BTN_RST = 1'b0; SW_ADJ = 1'b0; SW_SEL = 1'b0;
        pulses = 0; sel_hi = 0;
        step(3);
        check("reset_pause", PAUSE, 1'b0);
        check("reset_rst_pulse", RST_PULSE, 1'b0);
        check("reset_adj", ADJ, 1'b0);
        check("reset_sel", SEL, 1'b0);
        RESET = 1'b0;

        // 1: pause press qualifies on the 6th edge
        BTN_PAUSE = 1'b1;
        step(5);
        check("t1_pause_early", PAUSE, 1'b0);
        step(1);
        check("t1_pause_set", PAUSE, 1'b1);

        // 2: bouncy clear button, then held
        pulses = 0;
        BTN_RST = 1'b1; step_cnt(1);
        BTN_RST = 1'b0; step_cnt(1);
        BTN_RST = 1'b1; step_cnt(1);
        BTN_RST = 1'b0; step_cnt(1);
        BTN_RST = 1'b1; step_cnt(5);
        check("t2_no_bounce_pulse", pulses == 0, 1'b1);
        step(1);
        check("t2_rst_pulse", RST_PULSE, 1'b1);
        check("t2_pause_at_pulse", PAUSE, TOG ? 1'b0 : 1'b1);
        step(1);
        check("t2_pulse_one_cycle", RST_PULSE, 1'b0);
        pulses = 0;
        step_cnt(20);
        check("t2_hold_no_repeat", pulses == 0, 1'b1);
        BTN_RST = 1'b0; BTN_PAUSE = 1'b0;
        step(8);
        check("t2_pause_released", PAUSE, 1'b0);

        // 3: set pause, then clear press
        BTN_PAUSE = 1'b1;
        step(6);
        check("t3_pause_set", PAUSE, 1'b1);
        BTN_RST = 1'b1;
        step(5);
        check("t3_rst_early", RST_PULSE, 1'b0);
        step(1);
        check("t3_rst_pulse", RST_PULSE, 1'b1);
        check("t3_pause_at_pulse", PAUSE, TOG ? 1'b0 : 1'b1);
        BTN_RST = 1'b0; BTN_PAUSE = 1'b0;
        step(8);
        check("t3_pause_released", PAUSE, 1'b0);

        // 4: pause and clear rising together
        BTN_PAUSE = 1'b1; BTN_RST = 1'b1;
        step(5);
        check("t4_rst_early", RST_PULSE, 1'b0);
        step(1);
        check("t4_rst_pulse", RST_PULSE, 1'b1);
        check("t4_pause", PAUSE, TOG ? 1'b0 : 1'b1);
        step(1);
        check("t4_pulse_one_cycle", RST_PULSE, 1'b0);
        BTN_PAUSE = 1'b0; BTN_RST = 1'b0;
        step(8);

        // 5: 3-cycle glitch on select is rejected, stable edge accepted
        sel_hi = 0;
        SW_SEL = 1'b1; step_cnt(3);
        SW_SEL = 1'b0; step_cnt(6);
        check("t5_glitch_rejected", sel_hi == 0, 1'b1);
        SW_SEL = 1'b1;
        step(5);
        check("t5_sel_early", SEL, 1'b0);
        step(1);
        check("t5_sel_set", SEL, 1'b1);

        // 6: reset in the middle of adjust qualification
        SW_ADJ = 1'b1;
        step(2);
        RESET = 1'b1;
        step(1);
        check("t6_adj_in_reset", ADJ, 1'b0);
        check("t6_sel_in_reset", SEL, 1'b0);
        RESET = 1'b0;
        step(5);
        check("t6_adj_early", ADJ, 1'b0);
        step(1);
        check("t6_adj_set", ADJ, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
